// File: rtl/trace_frame_aligner_if.sv
// Trace aligner bus: DDR sample input side plus frame FIFO output and status side.
interface trace_frame_aligner_if #(
  parameter int MAX_WIDTH = 4
);
  logic [2:0]           width;
  logic [MAX_WIDTH-1:0] dina;
  logic [MAX_WIDTH-1:0] dinb;
  logic                 din_valid;
  logic [127:0]         frame_data;
  logic                 frame_valid;
  logic                 frame_ready;
  logic                 synced;
  logic [7:0]           overflow_cnt;

  modport master (
    output width, dina, dinb, din_valid, frame_ready,
    input  frame_data, frame_valid, synced, overflow_cnt
  );

  modport slave (
    input  width, dina, dinb, din_valid, frame_ready,
    output frame_data, frame_valid, synced, overflow_cnt
  );
endinterface

// File: rtl/trace_frame_aligner.sv
// TPIU trace aligner: finds FF FF FF 7F at any bit offset, packs 16-byte frames into a FIFO.
// Optional lock timeout is built when TRACE_ALIGNER_SYNC_TIMEOUT_EN is defined.
module trace_frame_aligner #(
  parameter int MAX_WIDTH    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  trace_frame_aligner_if.slave bus
);

  localparam int          BW        = 2 * MAX_WIDTH;
  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW        = PW + 1;
  localparam logic [4:0]  MAXW      = 5'(MAX_WIDTH);
  localparam logic [31:0] SYNC_WORD = 32'h7FFF_FFFF;

  typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_t;

  function automatic logic [4:0] clamp_width(input logic [2:0] code);
    logic [4:0] w;
    case (code)
      3'd0, 3'd1: w = 5'd1;
      3'd2:       w = 5'd2;
      3'd3:       w = 5'd4;
      3'd4:       w = 5'd8;
      default:    w = 5'd16;
    endcase
    return (w > MAXW) ? MAXW : w;
  endfunction

  state_t               state_r, state_s;
  logic                 synced_r;
  logic [31:0]          window_r, window_s;
  logic [6:0]           pos_r, pos_s;
  logic [127:0]         frame_r, frame_s;
  logic [4:0]           width_r, width_s;
  logic                 width_chg_s;
  logic [5:0]           nbits_s;
  logic [MAX_WIDTH-1:0] mask_s;
  logic [BW-1:0]        beat_s;
  logic                 push_s;
  logic [127:0]         push_frame_s;

  logic [127:0]         mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r, count_s;
  logic                 valid_r;
  logic [7:0]           ovf_r;
  logic                 full_s, pop_s, wr_en_s, drop_s;

`ifdef TRACE_ALIGNER_SYNC_TIMEOUT_EN
  localparam int TW = $clog2(SYNC_TIMEOUT + 1);
  logic [TW-1:0] tmo_r, tmo_s;
`endif

  assign width_s     = clamp_width(bus.width);
  assign width_chg_s = (width_s != width_r);
  assign nbits_s     = {width_s, 1'b0};

  // Lane mask for the active width
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      mask_s[i] = (i < int'(width_s));
    end
  end

  assign beat_s = {{MAX_WIDTH{1'b0}}, bus.dina & mask_s}
                | ({{MAX_WIDTH{1'b0}}, bus.dinb & mask_s} << width_s);

  // Walk every live bit of the beat in stream order: sync search first, then packing
  always_comb begin
    state_s      = state_r;
    window_s     = window_r;
    pos_s        = pos_r;
    frame_s      = frame_r;
    push_s       = 1'b0;
    push_frame_s = '0;
`ifdef TRACE_ALIGNER_SYNC_TIMEOUT_EN
    tmo_s        = tmo_r;
`endif
    if (width_chg_s) begin
      state_s  = UNSYNC;
      window_s = '0;
      pos_s    = '0;
      frame_s  = '0;
`ifdef TRACE_ALIGNER_SYNC_TIMEOUT_EN
      tmo_s    = '0;
`endif
    end else if (bus.din_valid) begin
      for (int i = 0; i < BW; i++) begin
        if (i < int'(nbits_s)) begin
          window_s = {beat_s[i], window_s[31:1]};
          if (window_s == SYNC_WORD) begin
            // A later match in the same beat simply realigns again
            state_s = SYNC;
            pos_s   = '0;
`ifdef TRACE_ALIGNER_SYNC_TIMEOUT_EN
            tmo_s   = '0;
`endif
          end else if (state_s == SYNC) begin
            frame_s[pos_s] = beat_s[i];
            if (pos_s == 7'd127) begin
              push_s       = 1'b1;
              push_frame_s = frame_s;
`ifdef TRACE_ALIGNER_SYNC_TIMEOUT_EN
              if (tmo_s == TW'(SYNC_TIMEOUT - 1)) begin
                state_s = UNSYNC;
                tmo_s   = '0;
              end else begin
                tmo_s = tmo_s + TW'(1);
              end
`endif
            end else begin
              push_s = push_s;
            end
            pos_s = pos_s + 7'd1;
          end else begin
            state_s = state_s;
          end
        end else begin
          window_s = window_s;
        end
      end
    end else begin
      state_s = state_r;
    end
  end

  // Aligner registers: lock state, sync window, partial frame, last clamped width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= UNSYNC;
      synced_r <= 1'b0;
      window_r <= '0;
      pos_r    <= '0;
      frame_r  <= '0;
      width_r  <= '0;
`ifdef TRACE_ALIGNER_SYNC_TIMEOUT_EN
      tmo_r    <= '0;
`endif
    end else begin
      state_r  <= state_s;
      synced_r <= (state_s == SYNC);
      window_r <= window_s;
      pos_r    <= pos_s;
      frame_r  <= frame_s;
      width_r  <= width_s;
`ifdef TRACE_ALIGNER_SYNC_TIMEOUT_EN
      tmo_r    <= tmo_s;
`endif
    end
  end

  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign pop_s   = valid_r && bus.frame_ready;
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;
  assign count_s = count_r + {{PW{1'b0}}, wr_en_s} - {{PW{1'b0}}, pop_s};

  // Frame FIFO with saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 8'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_frame_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (drop_s && (ovf_r != 8'hFF)) begin
        ovf_r <= ovf_r + 8'd1;
      end
      count_r <= count_s;
      valid_r <= (count_s != '0);
    end
  end

  assign bus.frame_data   = mem_r[rd_ptr_r];
  assign bus.frame_valid  = valid_r;
  assign bus.synced       = synced_r;
  assign bus.overflow_cnt = ovf_r;

endmodule

// File: tb/tb_trace_frame_aligner.sv
// Self-checking bench for trace_frame_aligner: vector table plus multi-cycle corner sequences.
module tb_trace_frame_aligner;

  localparam int MW = 8;

  logic clk;
  logic rst;
  int   tests_run;
  int   failed;

  trace_frame_aligner_if #(.MAX_WIDTH(MW)) bus_if ();

  trace_frame_aligner #(
    .MAX_WIDTH   (MW),
    .FIFO_DEPTH  (4),
    .SYNC_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct {
    logic [2:0]   width;
    int           pre_bits;
    logic [39:0]  pre;
    logic         synced_before;
    logic [127:0] frame;
  } vec_t;

  vec_t         vecs [7];
  logic         bitq [$];
  logic [127:0] exp_q [$];
  logic [127:0] fa, fb, fc, fd, fe, ff, fg, fh, fi, fj, fk;
  int           w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic int tb_width(input logic [2:0] code);
    int r;
    case (code)
      3'd0, 3'd1: r = 1;
      3'd2:       r = 2;
      3'd3:       r = 4;
      3'd4:       r = 8;
      default:    r = 16;
    endcase
    return (r > MW) ? MW : r;
  endfunction

  function automatic logic [127:0] mkframe(input int seed);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = 8'(seed * 16 + k);
    return f;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic q_bits(input logic [39:0] v, input int n);
    for (int i = 0; i < n; i++) bitq.push_back(v[i]);
  endtask

  task automatic q_sync();
    q_bits(40'h00_7FFF_FFFF, 32);
  endtask

  task automatic q_frame(input logic [127:0] f);
    for (int k = 0; k < 16; k++) q_bits({32'd0, f[8*k +: 8]}, 8);
  endtask

  task automatic q_pad(input int wd);
    while ((bitq.size() % (2 * wd)) != 0) bitq.push_back(1'b0);
  endtask

  // Unused upper lanes carry random junk that the DUT must ignore
  task automatic drive_beat(input int wd);
    logic [MW-1:0] a, b;
    a = MW'($urandom);
    b = MW'($urandom);
    for (int i = 0; i < wd; i++) a[i] = bitq.pop_front();
    for (int i = 0; i < wd; i++) b[i] = bitq.pop_front();
    bus_if.dina      = a;
    bus_if.dinb      = b;
    bus_if.din_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.din_valid = 1'b0;
  endtask

  task automatic flush(input int wd);
    while (bitq.size() >= 2 * wd) drive_beat(wd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  // Scoreboard: every accepted frame must match the oldest expected one
  always @(negedge clk) begin
    if (bus_if.frame_valid === 1'b1 && bus_if.frame_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        failed++;
        $display("FAIL unexpected_frame: got %0h, want none", bus_if.frame_data);
      end else begin
        check("frame", bus_if.frame_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    tests_run = 0;
    failed    = 0;
    fa = mkframe(1);  fb = mkframe(2);  fc = mkframe(3);  fd = mkframe(4);
    fe = mkframe(5);  ff = mkframe(6);  fg = mkframe(8);  fh = mkframe(9);
    fi = mkframe(10); fj = mkframe(11); fk = mkframe(12);

    vecs[0] = '{3'd3, 40, 40'h88_9900_0000, 1'b0, 128'h0f0e0d0c0b0a09080706050403023412};
    vecs[1] = '{3'd4, 3,  40'h0,            1'b0, 128'h0f0e0d0c0b0a09080706050403023412};
    vecs[2] = '{3'd5, 9,  40'h0AB,          1'b1, 128'h00112233445566778899aabbccddeeff};
    vecs[3] = '{3'd0, 5,  40'h0,            1'b0, 128'hdeadbeef0123456789abcdefcafef00d};
    vecs[4] = '{3'd1, 0,  40'h0,            1'b1, 128'h0123456789abcdeffedcba9876543210};
    vecs[5] = '{3'd2, 7,  40'h5,            1'b0, 128'h7e7e0000ffff123456789abcdef01357};
    vecs[6] = '{3'd7, 2,  40'h0,            1'b0, 128'h00112233445566778899aabbccddeeff};

    rst                = 1'b1;
    bus_if.width       = 3'd3;
    bus_if.dina        = '0;
    bus_if.dinb        = '0;
    bus_if.din_valid   = 1'b0;
    bus_if.frame_ready = 1'b1;
    #2 rst = 1'b0;
    idle(2);
    check("reset_valid",  128'(bus_if.frame_valid),  128'd0);
    check("reset_synced", 128'(bus_if.synced),       128'd0);
    check("reset_ovf",    128'(bus_if.overflow_cnt), 128'd0);
    check("reset_data",   bus_if.frame_data,         128'd0);
    rst = 1'b1;
    idle(3);

    // Table: lock at varied widths and bit offsets, one frame each
    for (int v = 0; v < 7; v++) begin
      bus_if.width = vecs[v].width;
      idle(2);
      w = tb_width(vecs[v].width);
      check($sformatf("v%0d_synced_before", v), 128'(bus_if.synced), 128'(vecs[v].synced_before));
      q_bits(vecs[v].pre, vecs[v].pre_bits);
      q_sync();
      flush(w);
      if (bitq.size() == 0) check($sformatf("v%0d_synced_at_sync", v), 128'(bus_if.synced), 128'd1);
      exp_q.push_back(vecs[v].frame);
      q_frame(vecs[v].frame);
      q_pad(w);
      flush(w);
      check($sformatf("v%0d_synced_after", v), 128'(bus_if.synced), 128'd1);
      wait_drain();
    end
    check("ovf_zero", 128'(bus_if.overflow_cnt), 128'd0);

    // Overflow: six frames into a full four-deep FIFO, then pop and push together
    bus_if.width = 3'd3;
    w = 4;
    idle(2);
    bus_if.frame_ready = 1'b0;
    q_sync(); q_frame(fa); q_frame(fb); q_frame(fc);
    q_sync(); q_frame(fd); q_frame(fe); q_frame(ff);
    exp_q.push_back(fa); exp_q.push_back(fb); exp_q.push_back(fc); exp_q.push_back(fd);
    flush(w);
    check("ovf_two",   128'(bus_if.overflow_cnt), 128'd2);
    check("ovf_valid", 128'(bus_if.frame_valid),  128'd1);
    check("ovf_head",  bus_if.frame_data,         fa);
    q_sync(); q_frame(fg);
    exp_q.push_back(fg);
    while (bitq.size() > 2 * w) drive_beat(w);
    bus_if.frame_ready = 1'b1;
    drive_beat(w);
    bus_if.frame_ready = 1'b0;
    check("ovf_hold_on_pop", 128'(bus_if.overflow_cnt), 128'd2);
    check("pop_push_head",   bus_if.frame_data,         fb);
    bus_if.frame_ready = 1'b1;
    wait_drain();

    // Mid-frame resync discards the partial frame
    q_sync();
    for (int k = 0; k < 8; k++) q_bits(40'(8'hA0 + k), 8);
    q_sync(); q_frame(fh);
    exp_q.push_back(fh);
    flush(w);
    wait_drain();

    // Width change drops lock but keeps queued frames
    bus_if.frame_ready = 1'b0;
    q_sync(); q_frame(fi);
    for (int k = 0; k < 5; k++) q_bits(40'(8'h10 + k), 8);
    flush(w);
    check("wchg_synced_before", 128'(bus_if.synced), 128'd1);
    bus_if.width = 3'd2;
    idle(1);
    check("wchg_synced", 128'(bus_if.synced),      128'd0);
    check("wchg_valid",  128'(bus_if.frame_valid), 128'd1);
    check("wchg_head",   bus_if.frame_data,        fi);
    exp_q.push_back(fi);
    bus_if.frame_ready = 1'b1;
    wait_drain();

    // Asynchronous reset mid-frame with two frames queued
    bus_if.width = 3'd3;
    idle(2);
    bus_if.frame_ready = 1'b0;
    q_sync(); q_frame(fj); q_frame(fk);
    for (int k = 0; k < 5; k++) q_bits(40'(8'h20 + k), 8);
    flush(w);
    check("pre_rst_valid", 128'(bus_if.frame_valid), 128'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid",  128'(bus_if.frame_valid),  128'd0);
    check("async_rst_synced", 128'(bus_if.synced),       128'd0);
    check("async_rst_ovf",    128'(bus_if.overflow_cnt), 128'd0);
    check("async_rst_data",   bus_if.frame_data,         128'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_if.frame_ready = 1'b1;
    idle(2);

    // Lock timeout: a sync before the fourth frame restarts the count
    q_sync(); q_frame(fa); q_frame(fb); q_frame(fc);
    exp_q.push_back(fa); exp_q.push_back(fb); exp_q.push_back(fc);
    flush(w);
    check("tmo_synced_3", 128'(bus_if.synced), 128'd1);
    q_sync(); q_frame(fd); q_frame(fe); q_frame(ff);
    exp_q.push_back(fd); exp_q.push_back(fe); exp_q.push_back(ff);
    flush(w);
    check("tmo_restart", 128'(bus_if.synced), 128'd1);
    q_frame(fg);
    exp_q.push_back(fg);
    flush(w);
`ifdef TRACE_ALIGNER_SYNC_TIMEOUT_EN
    check("tmo_drop", 128'(bus_if.synced), 128'd0);
    q_frame(fh);
    flush(w);
    check("tmo_stays_unsync", 128'(bus_if.synced), 128'd0);
`else
    check("lock_held", 128'(bus_if.synced), 128'd1);
    q_frame(fh);
    exp_q.push_back(fh);
    flush(w);
    check("lock_held_more", 128'(bus_if.synced), 128'd1);
`endif
    wait_drain();
    idle(3);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
